// File: rtl/mux_pkg.sv
// Shared definitions for the skid-buffered N:1 selector: state encoding and a width helper.
package mux_pkg;

   localparam logic [1:0] VACIO = 2'd0;
   localparam logic [1:0] UNO   = 2'd1;
   localparam logic [1:0] LLENO = 2'd2;

   typedef enum logic [1:0] {
      StVacio = VACIO,
      StUno   = UNO,
      StLleno = LLENO
   } estado_t;

   // Never returns 0 so that a selector port always has at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_n_to_1_comb.sv
// Combinational N:1 selector; out-of-range selectors yield zero data and a raised flag.
module mux_n_to_1_comb import mux_pkg::*; #(
   parameter int unsigned ANCHO      = 32,
   parameter int unsigned N_ENTRADAS = 4,
   parameter int unsigned SEL_W      = clog2(N_ENTRADAS)
) (
   input  logic [SEL_W-1:0]            i_selector,
   input  logic [N_ENTRADAS*ANCHO-1:0] i_entradas,
   output logic [ANCHO-1:0]            o_dato,
   output logic                        o_sel_invalido
);

   // The flag is simply "no input index matched".
   always_comb begin
      o_dato         = '0;
      o_sel_invalido = 1'b1;
      for (int unsigned k = 0; k < N_ENTRADAS; k++) begin
         if (i_selector == SEL_W'(k)) begin
            o_dato         = i_entradas[k*ANCHO +: ANCHO];
            o_sel_invalido = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_n_to_1_skid.sv
// N:1 selector with registered output, one-entry skid buffer, registered ready and stage flush.
module mux_n_to_1_skid import mux_pkg::*; #(
   parameter int unsigned ANCHO      = 32,
   parameter int unsigned N_ENTRADAS = 4,
   parameter int unsigned SEL_W      = clog2(N_ENTRADAS)
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_flush,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [SEL_W-1:0]            i_selector,
   input  logic [N_ENTRADAS*ANCHO-1:0] i_entradas,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [ANCHO-1:0]            o_salidaMUX,
   output logic                        o_sel_invalido
);

   estado_t          estado_q, estado_d;
   logic             ready_q, ready_d;
   logic [ANCHO-1:0] sal_q, sal_d, skid_q, skid_d;
   logic             sal_inv_q, sal_inv_d, skid_inv_q, skid_inv_d;
   logic [ANCHO-1:0] sel_dato;
   logic             sel_inv;
   logic             acepta, drena;

   mux_n_to_1_comb #(
      .ANCHO      (ANCHO),
      .N_ENTRADAS (N_ENTRADAS),
      .SEL_W      (SEL_W)
   ) u_comb (
      .i_selector     (i_selector),
      .i_entradas     (i_entradas),
      .o_dato         (sel_dato),
      .o_sel_invalido (sel_inv)
   );

   assign acepta = i_valid & ready_q;
   assign drena  = (estado_q != StVacio) & i_ready;

   always_comb begin
      estado_d   = estado_q;
      sal_d      = sal_q;
      sal_inv_d  = sal_inv_q;
      skid_d     = skid_q;
      skid_inv_d = skid_inv_q;
      if (i_flush) begin
         estado_d   = StVacio;
         sal_d      = '0;
         sal_inv_d  = 1'b0;
         skid_d     = '0;
         skid_inv_d = 1'b0;
      end else begin
         case (estado_q)
            StVacio: begin
               if (acepta) begin
                  sal_d     = sel_dato;
                  sal_inv_d = sel_inv;
                  estado_d  = StUno;
               end
            end
            StUno: begin
               if (acepta && drena) begin
                  sal_d     = sel_dato;
                  sal_inv_d = sel_inv;
               end else if (acepta) begin
                  skid_d     = sel_dato;
                  skid_inv_d = sel_inv;
                  estado_d   = StLleno;
               end else if (drena) begin
                  estado_d = StVacio;
               end
            end
            StLleno: begin
               if (drena) begin
                  sal_d      = skid_q;
                  sal_inv_d  = skid_inv_q;
                  skid_d     = '0;
                  skid_inv_d = 1'b0;
                  estado_d   = StUno;
               end
            end
            default: estado_d = StVacio;
         endcase
      end
   end

   // Ready comes from the next state, so it is a flop with no path from i_ready.
   assign ready_d = (estado_d != StLleno);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         estado_q   <= StVacio;
         ready_q    <= 1'b0;
         sal_q      <= '0;
         sal_inv_q  <= 1'b0;
         skid_q     <= '0;
         skid_inv_q <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         ready_q    <= ready_d;
         sal_q      <= sal_d;
         sal_inv_q  <= sal_inv_d;
         skid_q     <= skid_d;
         skid_inv_q <= skid_inv_d;
      end
   end

   assign o_ready        = ready_q;
   assign o_valid        = (estado_q != StVacio);
   assign o_salidaMUX    = sal_q;
   assign o_sel_invalido = sal_inv_q;

endmodule

// File: tb/tb_mux_n_to_1_skid.sv
// Scoreboard bench for mux_n_to_1_skid with N=5 inputs (3-bit selector, so 5..7 are out of range).
module tb_mux_n_to_1_skid;

   localparam int unsigned W = 32;
   localparam int unsigned N = 5;
   localparam int unsigned S = 3;

   logic           i_clk, i_reset, i_flush, i_valid, i_ready;
   logic           o_ready, o_valid, o_sel_invalido;
   logic [S-1:0]   i_selector;
   logic [N*W-1:0] i_entradas;
   logic [W-1:0]   o_salidaMUX;

   int total = 0;
   int bad   = 0;
   logic [W:0] exp_q[$];

   mux_n_to_1_skid #(
      .ANCHO      (W),
      .N_ENTRADAS (N)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_flush        (i_flush),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_selector     (i_selector),
      .i_entradas     (i_entradas),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_salidaMUX    (o_salidaMUX),
      .o_sel_invalido (o_sel_invalido)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Reference: pick input sel, or {flag=1, data=0} when sel does not name an input.
   function automatic logic [W:0] ref_sel(input int sel, input logic [N*W-1:0] ent);
      logic [W:0] r;
      if (sel >= int'(N)) r = {1'b1, {W{1'b0}}};
      else r = {1'b0, ent[sel*W +: W]};
      return r;
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input int sel, input logic [W-1:0] val);
      i_valid    = 1'b1;
      i_selector = S'(sel);
      if (sel < int'(N)) i_entradas[sel*W +: W] = val;
   endtask

   // Recorder: every accepted item (at the coming edge) enters the expected queue.
   initial forever begin
      @(negedge i_clk);
      if (i_reset || i_flush) exp_q.delete();
      else if (i_valid && o_ready) exp_q.push_back(ref_sel(int'(i_selector), i_entradas));
   end

   // Monitor: compares every drained item and checks the output holds while stalled.
   initial begin
      logic       stall_prev;
      logic [W:0] held, e;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge i_clk);
         if (i_reset || i_flush) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev)
               chk("stall_hold", {o_valid, o_sel_invalido, o_salidaMUX}, {1'b1, held});
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_spurious got=%0h exp=none", o_salidaMUX);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_data", {o_sel_invalido, o_salidaMUX}, e);
               end
            end
            stall_prev = o_valid && !i_ready;
            held       = {o_sel_invalido, o_salidaMUX};
         end
      end
   end

   initial begin
      int acc_n, cyc;
      i_reset    = 1'b1;
      i_flush    = 1'b0;
      i_valid    = 1'b0;
      i_ready    = 1'b0;
      i_selector = '0;
      i_entradas = '0;
      repeat (2) step();
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", {o_sel_invalido, o_salidaMUX}, 0);
      i_reset = 1'b0;
      step();
      chk("ready_after_release", o_ready, 1);

      // Back-to-back, each visible one cycle after accept.
      for (int j = 0; j < int'(N); j++) i_entradas[j*W +: W] = W'(32'hA0 + j);
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send(k, W'(32'hA0 + k));
         step();
         chk("b2b_valid", o_valid, 1);
         chk("b2b_data", o_salidaMUX, 32'hA0 + k);
      end
      i_valid = 1'b0;
      step();
      chk("b2b_empty", o_valid, 0);

      // Backpressure into the skid entry.
      i_ready = 1'b0;
      send(0, 32'h11);
      step();
      chk("bp_ready1", o_ready, 1);
      chk("bp_data1", o_salidaMUX, 32'h11);
      send(0, 32'h22);
      step();
      chk("bp_ready_full", o_ready, 0);
      chk("bp_hold", o_salidaMUX, 32'h11);
      i_valid = 1'b0;
      step();
      chk("bp_hold2", o_salidaMUX, 32'h11);
      i_ready = 1'b1;
      step();
      chk("bp_drain_data", o_salidaMUX, 32'h22);
      chk("bp_ready_back", o_ready, 1);
      step();
      chk("bp_drained", o_valid, 0);

      // Out-of-range selector, then the top valid index.
      send(7, 32'h0);
      step();
      chk("inv_data", o_salidaMUX, 0);
      chk("inv_flag", o_sel_invalido, 1);
      send(4, 32'hA4);
      step();
      chk("sel4_flag", o_sel_invalido, 0);
      chk("sel4_data", o_salidaMUX, 32'hA4);
      i_valid = 1'b0;
      step();

      // Flush while full with i_valid high.
      i_ready = 1'b0;
      send(1, 32'h33);
      step();
      send(2, 32'h44);
      step();
      chk("fl_full", o_ready, 0);
      send(3, 32'h55);
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      i_valid = 1'b0;
      chk("fl_valid", o_valid, 0);
      chk("fl_ready", o_ready, 1);
      chk("fl_data", {o_sel_invalido, o_salidaMUX}, 0);
      // Flush while an accept is happening: the accepted item must vanish.
      send(1, 32'h66);
      step();
      send(2, 32'h77);
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      step();
      chk("fl_acc_dropped", o_valid, 0);

      // Asynchronous reset mid-stream.
      i_ready = 1'b0;
      send(3, 32'h88);
      step();
      i_valid = 1'b0;
      chk("ar_pre_valid", o_valid, 1);
      i_reset = 1'b1;
      #1;
      chk("ar_valid", o_valid, 0);
      chk("ar_data", o_salidaMUX, 0);
      chk("ar_ready", o_ready, 0);
      step();
      i_reset = 1'b0;
      step();
      chk("ar_ready_release", o_ready, 1);

      // Randomised traffic.
      acc_n = 0;
      cyc   = 0;
      while (acc_n < 1000 && cyc < 20000) begin
         i_valid    = ($urandom_range(0, 3) != 0);
         i_selector = S'($urandom_range(0, 7));
         for (int j = 0; j < int'(N); j++) i_entradas[j*W +: W] = $urandom;
         i_ready    = ($urandom_range(0, 2) != 0);
         if (i_valid && o_ready) acc_n++;
         step();
         cyc++;
      end
      chk("rand_items", acc_n, 1000);
      i_valid = 1'b0;
      i_ready = 1'b1;
      repeat (4) step();
      chk("sb_empty", exp_q.size(), 0);
      chk("end_valid", o_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
